// File: rtl/ins_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM encoding,
// fetched-word record and the optional instruction-cache geometry.
package ins_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_HOLD     = 2'd2,
    S_DROP     = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } fetch_word_t;

  localparam logic [31:0] PC_STEP  = 32'd4;
  localparam int          IC_LINES = 16;
  localparam int          IC_IDX_W = 4;
  localparam int          IC_TAG_W = 26;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/ins_fetch_icache.sv
// Direct-mapped, one-word-per-line instruction cache (index pc[5:2], tag pc[31:6]).
// Only exists when FETCH_ICACHE_EN is defined.
`ifdef FETCH_ICACHE_EN
module fetch_icache
  import ins_fetch_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:2] lk_addr,
  output logic        lk_hit,
  output logic [31:0] lk_data,
  input  logic        fill_we,
  input  logic [31:2] fill_addr,
  input  logic [31:0] fill_data
);

  logic [IC_LINES-1:0]               vld_q, vld_d;
  logic [IC_LINES-1:0][IC_TAG_W-1:0] tag_q, tag_d;
  logic [IC_LINES-1:0][31:0]         data_q, data_d;

  logic [IC_IDX_W-1:0] lk_idx, fill_idx;
  assign lk_idx   = lk_addr[5:2];
  assign fill_idx = fill_addr[5:2];

  assign lk_hit  = vld_q[lk_idx] && (tag_q[lk_idx] == lk_addr[31:6]);
  assign lk_data = data_q[lk_idx];

  always_comb begin
    vld_d  = vld_q;
    tag_d  = tag_q;
    data_d = data_q;
    if (fill_we) begin
      vld_d[fill_idx]  = 1'b1;
      tag_d[fill_idx]  = fill_addr[31:6];
      data_d[fill_idx] = fill_data;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      vld_q  <= '0;
      tag_q  <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      tag_q  <= tag_d;
      data_q <= data_d;
    end
  end

endmodule
`endif

// File: rtl/ins_fetch.sv
// Single-outstanding instruction fetch FSM with flush redirect and global stall.
// Define FETCH_ICACHE_EN to add a small direct-mapped instruction cache.
module ins_fetch
  import ins_fetch_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_data,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        flush,
  input  logic [31:0] flush_pc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  fetch_word_t  out_q, out_d;
  logic         ins_valid_q, ins_valid_d;
  logic         mem_req_q, mem_req_d;
  logic [31:0]  mem_addr_q, mem_addr_d;

`ifdef FETCH_ICACHE_EN
  logic        ic_hit;
  logic [31:0] ic_data;
  logic        fill_we;

  // Fill only with responses that are actually delivered, never dropped ones.
  assign fill_we = rdy_in && (state_q == S_WAIT_MEM) && mem_valid && !flush;

  fetch_icache u_icache (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .lk_addr   (pc_q[31:2]),
    .lk_hit    (ic_hit),
    .lk_data   (ic_data),
    .fill_we   (fill_we),
    .fill_addr (mem_addr_q[31:2]),
    .fill_data (mem_data)
  );
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_d       = out_q;
    ins_valid_d = ins_valid_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    if (rdy_in) begin
      unique case (state_q)
        S_IDLE: begin
          if (flush) begin
            pc_d        = align_pc(flush_pc);
            ins_valid_d = 1'b0;
          end else
`ifdef FETCH_ICACHE_EN
          if (ic_hit) begin
            out_d       = '{ins: ic_data, pc: pc_q};
            ins_valid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
            state_d     = S_HOLD;
          end else
`endif
          begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            state_d    = S_WAIT_MEM;
          end
        end
        S_WAIT_MEM: begin
          if (flush) begin
            // A response still in flight must be swallowed in DROP.
            pc_d      = align_pc(flush_pc);
            mem_req_d = 1'b0;
            state_d   = mem_valid ? S_IDLE : S_DROP;
          end else if (mem_valid) begin
            out_d       = '{ins: mem_data, pc: pc_q};
            ins_valid_d = 1'b1;
            pc_d        = pc_q + PC_STEP;
            mem_req_d   = 1'b0;
            state_d     = S_HOLD;
          end
        end
        S_HOLD: begin
          if (flush) begin
            ins_valid_d = 1'b0;
            pc_d        = align_pc(flush_pc);
            state_d     = S_IDLE;
          end else if (ins_valid_q && ins_ready) begin
            ins_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        S_DROP: begin
          if (flush) pc_d = align_pc(flush_pc);
          // The late response is the one being waited for, even with a new flush.
          if (mem_valid) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      out_q       <= '0;
      ins_valid_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_q       <= out_d;
      ins_valid_q <= ins_valid_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign ins       = out_q.ins;
  assign ins_pc    = out_q.pc;
  assign ins_valid = ins_valid_q;

endmodule
